pipe_hazard_ctrl: RTL and testbench

Hazard and flush controller for the 5-stage pipelined CPU. It is the producer side of the pipeline-register control interface: it drives the write-enable (e) and Condep clear inputs of the IF/ID and ID/EX Dffe registers, the PC enable, and the ID-stage forwarding selects. It detects load-use hazards, applies taken-branch flushes and freezes the pipe during multi-cycle memory access. It also keeps stall and flush event counters for debug.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/fwd_unit.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller:
// FSM state encoding and operand-forwarding select codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StFlush   = 2'd1,
        StMemWait = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_EXALU  = 2'b01;
    localparam logic [1:0] FWD_MEMALU = 2'b10;
    localparam logic [1:0] FWD_MEMLD  = 2'b11;

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding select for one ID-stage source operand.
// EX has precedence over MEM; register $0 is never forwarded.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_wn,
    input  logic       mem_wreg,
    input  logic       mem_m2reg,
    input  logic [4:0] mem_wn,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REG;
        // A load in EX has no data yet; the load-use stall covers that case.
        if (ex_wreg && !ex_m2reg && (ex_wn != 5'd0) && (ex_wn == src)) begin
            sel = FWD_EXALU;
        end else if (mem_wreg && (mem_wn != 5'd0) && (mem_wn == src)) begin
            sel = mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush controller: drives PC/IF/ID enables, Condep clears and
// forwarding selects; counts stall cycles and applied branch flushes.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       ex_wn,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic [4:0]       mem_wn,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_condep,
    output logic             idex_condep,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic             br_pend_q, br_pend_d;
    logic             flush_apply;
    logic             load_use;
    logic [1:0]       fwda_raw, fwdb_raw;
    logic [CNT_W-1:0] stall_q, flush_q;

    assign load_use = ex_wreg && ex_m2reg && (ex_wn != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_wn)) || (id_use_rt && (id_rt == ex_wn)));

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_condep = 1'b0;
        idex_condep = 1'b0;
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        br_pend_d   = br_pend_q;
        flush_apply = 1'b0;
        if (Clr) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_condep = 1'b1;
            idex_condep = 1'b1;
        end else if (mem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            state_d = StMemWait;
            fcnt_d  = 2'd0;
            // An interrupted flush is replayed once memory is ready.
            if (br_taken || (state_q == StFlush)) begin
                br_pend_d = 1'b1;
            end
        end else if (br_taken || br_pend_q) begin
            ifid_condep = 1'b1;
            idex_condep = 1'b1;
            flush_apply = 1'b1;
            br_pend_d   = 1'b0;
            if (FLUSH_CYCLES > 0) begin
                fcnt_d  = 2'(FLUSH_CYCLES);
                state_d = StFlush;
            end else begin
                state_d = StRun;
            end
        end else if (state_q == StFlush) begin
            ifid_condep = 1'b1;
            fcnt_d      = fcnt_q - 2'd1;
            if (fcnt_q <= 2'd1) begin
                state_d = StRun;
            end
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_condep = 1'b1;
            state_d     = StRun;
        end else begin
            state_d = StRun;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q   <= StRun;
            fcnt_q    <= 2'd0;
            br_pend_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            br_pend_q <= br_pend_d;
            if (!pc_we) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_apply) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    fwd_unit u_fwd_rs (
        .src       (id_rs),
        .ex_wreg   (ex_wreg),
        .ex_m2reg  (ex_m2reg),
        .ex_wn     (ex_wn),
        .mem_wreg  (mem_wreg),
        .mem_m2reg (mem_m2reg),
        .mem_wn    (mem_wn),
        .sel       (fwda_raw)
    );

    fwd_unit u_fwd_rt (
        .src       (id_rt),
        .ex_wreg   (ex_wreg),
        .ex_m2reg  (ex_m2reg),
        .ex_wn     (ex_wn),
        .mem_wreg  (mem_wreg),
        .mem_m2reg (mem_m2reg),
        .mem_wn    (mem_wn),
        .sel       (fwdb_raw)
    );

    assign fwda      = Clr ? FWD_REG : fwda_raw;
    assign fwdb      = Clr ? FWD_REG : fwdb_raw;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W = 32;

    logic             Clk = 1'b0;
    logic             Clr = 1'b1;
    logic [4:0]       id_rs = '0, id_rt = '0, ex_wn = '0, mem_wn = '0;
    logic             id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic             ex_wreg = 1'b0, ex_m2reg = 1'b0, mem_wreg = 1'b0, mem_m2reg = 1'b0;
    logic             br_taken = 1'b0, mem_busy = 1'b0;
    logic             pc_we, ifid_we, ifid_condep, idex_condep;
    logic [1:0]       fwda, fwdb;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        int          id;
        logic [3:0]  ctl;   // {pc_we, ifid_we, ifid_condep, idex_condep}
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        chk_cnt;
        logic [31:0] st;
        logic [31:0] fl;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   vec_id = 0;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES (1),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Clr         (Clr),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .ex_wreg     (ex_wreg),
        .ex_m2reg    (ex_m2reg),
        .ex_wn       (ex_wn),
        .mem_wreg    (mem_wreg),
        .mem_m2reg   (mem_m2reg),
        .mem_wn      (mem_wn),
        .br_taken    (br_taken),
        .mem_busy    (mem_busy),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_condep (ifid_condep),
        .idex_condep (idex_condep),
        .fwda        (fwda),
        .fwdb        (fwdb),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 Clk = ~Clk;

    // Drive one cycle of inputs just after the edge and queue its expected outputs.
    task automatic cyc(input logic clr, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic ewr, input logic em2, input logic [4:0] ewn,
                       input logic mwr, input logic mm2, input logic [4:0] mwn,
                       input logic br, input logic busy,
                       input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                       input logic chk, input int st, input int fl);
        exp_t e;
        @(posedge Clk);
        #1;
        Clr = clr; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        ex_wreg = ewr; ex_m2reg = em2; ex_wn = ewn;
        mem_wreg = mwr; mem_m2reg = mm2; mem_wn = mwn;
        br_taken = br; mem_busy = busy;
        vec_id++;
        e.id = vec_id; e.ctl = ctl; e.fa = fa; e.fb = fb;
        e.chk_cnt = chk; e.st = st; e.fl = fl;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [3:0] ctl, input int st, input int fl);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl, 2'b00, 2'b00, 1, st, fl);
    endtask

    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e = sb.pop_front();
            act = {pc_we, ifid_we, ifid_condep, idex_condep};
            tests++;
            if (act !== e.ctl) begin
                fails++;
                $display("FAIL ctl v%0d: got %b want %b", e.id, act, e.ctl);
            end
            tests++;
            if ({fwda, fwdb} !== {e.fa, e.fb}) begin
                fails++;
                $display("FAIL fwd v%0d: got %b/%b want %b/%b", e.id, fwda, fwdb, e.fa, e.fb);
            end
            if (e.chk_cnt) begin
                tests++;
                if (stall_cnt !== e.st || flush_cnt !== e.fl) begin
                    fails++;
                    $display("FAIL cnt v%0d: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                             e.id, stall_cnt, flush_cnt, e.st, e.fl);
                end
            end
        end
    end

    initial begin
        // Reset: controls forced, counters cleared after the first edge.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 2'b00, 2'b00, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 2'b00, 2'b00, 1, 0, 0);
        idle(4'b1100, 0, 0);
        // Load-use on rs: exactly one bubble.
        cyc(0, 8, 0, 1, 0, 1, 1, 8, 0, 0, 0, 0, 0, 4'b0001, 2'b00, 2'b00, 1, 0, 0);
        idle(4'b1100, 1, 0);
        // Load targeting $0: no stall.
        cyc(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'b1100, 2'b00, 2'b00, 1, 1, 0);
        // Load-use on rt.
        cyc(0, 0, 9, 0, 1, 1, 1, 9, 0, 0, 0, 0, 0, 4'b0001, 2'b00, 2'b00, 1, 1, 0);
        idle(4'b1100, 2, 0);
        // Taken branch with one extra flush cycle.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 2'b00, 2'b00, 1, 2, 0);
        idle(4'b1110, 2, 1);
        idle(4'b1100, 2, 1);
        // mem_busy for 3 cycles, branch in the 2nd; flush applied on release.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b00, 2'b00, 1, 2, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b00, 1, 3, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b00, 2'b00, 1, 4, 1);
        idle(4'b1111, 5, 1);
        idle(4'b1110, 5, 2);
        idle(4'b1100, 5, 2);
        // Forwarding selects.
        cyc(0, 5, 0, 1, 0, 1, 0, 5, 1, 0, 5, 0, 0, 4'b1100, 2'b01, 2'b00, 1, 5, 2);
        cyc(0, 5, 5, 1, 1, 0, 0, 5, 1, 1, 5, 0, 0, 4'b1100, 2'b11, 2'b11, 1, 5, 2);
        cyc(0, 3, 5, 1, 1, 0, 0, 5, 1, 0, 5, 0, 0, 4'b1100, 2'b00, 2'b10, 1, 5, 2);
        cyc(0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 4'b1100, 2'b00, 2'b00, 1, 5, 2);
        cyc(0, 7, 7, 1, 1, 1, 0, 7, 1, 1, 7, 0, 0, 4'b1100, 2'b01, 2'b01, 1, 5, 2);
        // Branch during FLUSH restarts the flush and is counted.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 2'b00, 2'b00, 1, 5, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 2'b00, 2'b00, 1, 5, 3);
        idle(4'b1110, 5, 4);
        idle(4'b1100, 5, 4);
        // mem_busy during FLUSH: freeze, then replay the flush.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 2'b00, 2'b00, 1, 5, 4);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b00, 2'b00, 1, 5, 5);
        idle(4'b1111, 6, 5);
        idle(4'b1110, 6, 6);
        idle(4'b1100, 6, 6);
        // Clr in the middle of FLUSH.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 2'b00, 2'b00, 1, 6, 6);
        cyc(1, 5, 5, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 4'b0011, 2'b00, 2'b00, 1, 6, 7);
        idle(4'b1100, 0, 0);
        // Clr while a branch is pending in MEM_WAIT drops the pending flush.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000, 2'b00, 2'b00, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 2'b00, 2'b00, 1, 1, 0);
        idle(4'b1100, 0, 0);
        idle(4'b1100, 0, 0);

        @(posedge Clk);
        @(negedge Clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
